// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 port between NUM_REQ L1 requesters, one transaction at a time.
// Optional per-port performance counters are enabled by defining L2_ARB_PERF_EN.
module l2_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]          req_addr,
    input  logic [NUM_REQ*BLOCK_SIZE*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]                     req_read,
    input  logic [NUM_REQ-1:0]                     req_write,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic [NUM_REQ-1:0]                     req_hit,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0]       req_rdata,
    output logic [NUM_REQ-1:0]                     grant,
    output logic                                   busy,
    output logic [ADDR_WIDTH-1:0]                  l2_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0]       l2_wdata,
    output logic                                   l2_read,
    output logic                                   l2_write,
    input  logic                                   l2_ready,
    input  logic                                   l2_hit,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]       l2_rdata
`ifdef L2_ARB_PERF_EN
   ,output logic [NUM_REQ*32-1:0]                  perf_grants,
    output logic [NUM_REQ*32-1:0]                  perf_stall
`endif
);

    localparam int LINE_W = BLOCK_SIZE * DATA_WIDTH;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e                  state_r;
    logic [NUM_REQ-1:0]      pending_r;
    logic [NUM_REQ-1:0]      op_wr_r;
    logic [ADDR_WIDTH-1:0]   addr_r  [NUM_REQ];
    logic [LINE_W-1:0]       wdata_r [NUM_REQ];
    logic [IDX_W-1:0]        rr_r;
    logic [IDX_W-1:0]        gnt_idx_r;

    logic [IDX_W-1:0]        win_idx_s;
    logic                    win_valid_s;
    logic [IDX_W-1:0]        rr_next_s;
    logic                    done_s;
    logic [NUM_REQ-1:0]      done_vec_s;
    logic [NUM_REQ-1:0]      cap_s;

    // Returns {valid, index} of the first pending port at or above ptr, wrapping around.
    function automatic logic [IDX_W:0] find_winner(input logic [NUM_REQ-1:0] pend,
                                                    input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end else begin
                sum = sum;
            end
            idx = sum[IDX_W-1:0];
            if (pend[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Winner selection, completion detection and next round-robin pointer.
    always_comb begin
        {win_valid_s, win_idx_s} = find_winner(pending_r, rr_r);
        done_s = ((state_r == ST_REQ) || (state_r == ST_WAIT)) && l2_ready;
        if (done_s) begin
            done_vec_s = grant;
        end else begin
            done_vec_s = '0;
        end
        if (gnt_idx_r == IDX_W'(NUM_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = gnt_idx_r + IDX_W'(1);
        end
        // A port completing this cycle may re-arm its slot on the same edge.
        cap_s = (req_read | req_write) & (~pending_r | done_vec_s);
    end

    // Per-port pending slots: capture new requests, release on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= '0;
            op_wr_r   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                addr_r[i]  <= '0;
                wdata_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cap_s[i]) begin
                    pending_r[i] <= 1'b1;
                    op_wr_r[i]   <= req_write[i];
                    addr_r[i]    <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_r[i]   <= req_wdata[i*LINE_W +: LINE_W];
                end else if (done_vec_s[i]) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
        end
    end

    // Transaction FSM driving the L2 port and the per-port completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            rr_r      <= '0;
            gnt_idx_r <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            l2_addr   <= '0;
            l2_wdata  <= '0;
            l2_read   <= 1'b0;
            l2_write  <= 1'b0;
            req_ready <= '0;
            req_hit   <= '0;
            req_rdata <= '0;
        end else begin
            l2_read   <= 1'b0;
            l2_write  <= 1'b0;
            req_ready <= '0;
            req_hit   <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
                        gnt_idx_r <= win_idx_s;
                        l2_addr   <= addr_r[win_idx_s];
                        l2_wdata  <= wdata_r[win_idx_s];
                        l2_write  <= op_wr_r[win_idx_s];
                        l2_read   <= ~op_wr_r[win_idx_s];
                        busy      <= 1'b1;
                        state_r   <= ST_REQ;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (l2_ready) begin
                        req_rdata <= l2_rdata;
                        req_ready <= grant;
                        req_hit   <= l2_hit ? grant : '0;
                        rr_r      <= rr_next_s;
                        grant     <= '0;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_WAIT;
                    end
                end
                default: begin
                    grant   <= '0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef L2_ARB_PERF_EN
    // Saturating per-port completion and stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grants <= '0;
            perf_stall  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done_vec_s[i] && (perf_grants[i*32 +: 32] != 32'hFFFF_FFFF)) begin
                    perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32] + 32'd1;
                end else begin
                    perf_grants[i*32 +: 32] <= perf_grants[i*32 +: 32];
                end
                if (pending_r[i] && !grant[i] && (perf_stall[i*32 +: 32] != 32'hFFFF_FFFF)) begin
                    perf_stall[i*32 +: 32] <= perf_stall[i*32 +: 32] + 32'd1;
                end else begin
                    perf_stall[i*32 +: 32] <= perf_stall[i*32 +: 32];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed self-checking bench for l2_port_arbiter (two ports, 512-bit lines).
module tb_l2_port_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   req_addr;
    logic [1023:0] req_wdata;
    logic [1:0]    req_read;
    logic [1:0]    req_write;
    logic [1:0]    req_ready;
    logic [1:0]    req_hit;
    logic [511:0]  req_rdata;
    logic [1:0]    grant;
    logic          busy;
    logic [31:0]   l2_addr;
    logic [511:0]  l2_wdata;
    logic          l2_read;
    logic          l2_write;
    logic          l2_ready;
    logic          l2_hit;
    logic [511:0]  l2_rdata;
`ifdef L2_ARB_PERF_EN
    logic [63:0]   perf_grants;
    logic [63:0]   perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    l2_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_read(req_read), .req_write(req_write),
        .req_ready(req_ready), .req_hit(req_hit), .req_rdata(req_rdata),
        .grant(grant), .busy(busy),
        .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_read(l2_read), .l2_write(l2_write),
        .l2_ready(l2_ready), .l2_hit(l2_hit), .l2_rdata(l2_rdata)
`ifdef L2_ARB_PERF_EN
       ,.perf_grants(perf_grants), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    typedef struct {
        int           port;
        logic         rd;
        logic         wr;
        logic         redo;
        logic [31:0]  addr;
        logic [511:0] wline;
        int           lat;
        logic         hit;
        logic [511:0] rline;
        logic [1:0]   exp_grant;
        logic         exp_l2_rd;
        logic         exp_l2_wr;
        logic [1:0]   exp_ready;
        logic [1:0]   exp_hit;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic issue_chk(input string tag, input logic [1:0] g, input logic [31:0] a,
                             input logic rd, input logic wr);
        chk({tag, "_grant"},    64'(grant),    64'(g));
        chk({tag, "_l2_addr"},  64'(l2_addr),  64'(a));
        chk({tag, "_l2_read"},  64'(l2_read),  64'(rd));
        chk({tag, "_l2_write"}, 64'(l2_write), 64'(wr));
        chk({tag, "_busy"},     64'(busy),     64'(1'b1));
    endtask

    // Called just after the issue edge; returns just after the completion edge.
    task automatic respond(input string tag, input int lat, input logic hit, input logic [511:0] line,
                           input logic [1:0] exp_rdy, input logic [1:0] exp_hit, input logic [1:0] rereq);
        for (int c = 1; c < lat; c++) begin
            step();
            chk({tag, "_strobe_low"}, 64'({l2_read, l2_write}), 64'(2'b00));
            chk({tag, "_no_early_ready"}, 64'(req_ready), 64'(2'b00));
        end
        l2_ready = 1'b1;
        l2_hit   = hit;
        l2_rdata = line;
        req_read = rereq;
        step();
        l2_ready = 1'b0;
        l2_hit   = 1'b0;
        req_read = 2'b00;
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(exp_rdy));
        chk({tag, "_req_hit"},   64'(req_hit),   64'(exp_hit));
        chk_line({tag, "_req_rdata"}, req_rdata, line);
        chk({tag, "_done_strobe_low"}, 64'({l2_read, l2_write}), 64'(2'b00));
        chk({tag, "_done_grant"}, 64'(grant), 64'(2'b00));
        chk({tag, "_done_busy"},  64'(busy),  64'(1'b0));
    endtask

    task automatic idle_tail(input string tag, input int n, input logic [511:0] line);
        for (int c = 0; c < n; c++) begin
            step();
            chk({tag, "_tail_strobe"}, 64'({l2_read, l2_write}), 64'(2'b00));
            chk({tag, "_tail_grant"},  64'(grant),     64'(2'b00));
            chk({tag, "_tail_ready"},  64'(req_ready), 64'(2'b00));
            chk_line({tag, "_tail_rdata_hold"}, req_rdata, line);
        end
    endtask

    initial begin
        logic [511:0] lw0, lw1, lr0, lr1, lr2;
        int           p;
        string        tag;

        lw0 = {16{32'hD00D_0080}};
        lw1 = {16{32'hBEEF_0300}};
        lr0 = {16{32'hCAFE_0040}};
        lr1 = {16{32'h1234_5678}};
        lr2 = {16{32'h0F0F_F0F0}};

        vecs[0] = '{port: 0, rd: 1'b1, wr: 1'b0, redo: 1'b0, addr: 32'h0000_0040, wline: lw0,
                    lat: 3, hit: 1'b1, rline: lr0, exp_grant: 2'b01, exp_l2_rd: 1'b1,
                    exp_l2_wr: 1'b0, exp_ready: 2'b01, exp_hit: 2'b01};
        vecs[1] = '{port: 1, rd: 1'b1, wr: 1'b0, redo: 1'b0, addr: 32'h1234_5678, wline: lw1,
                    lat: 2, hit: 1'b0, rline: lr1, exp_grant: 2'b10, exp_l2_rd: 1'b1,
                    exp_l2_wr: 1'b0, exp_ready: 2'b10, exp_hit: 2'b00};
        vecs[2] = '{port: 0, rd: 1'b0, wr: 1'b1, redo: 1'b0, addr: 32'h0000_0080, wline: lw0,
                    lat: 1, hit: 1'b1, rline: lr2, exp_grant: 2'b01, exp_l2_rd: 1'b0,
                    exp_l2_wr: 1'b1, exp_ready: 2'b01, exp_hit: 2'b01};
        vecs[3] = '{port: 1, rd: 1'b1, wr: 1'b1, redo: 1'b1, addr: 32'h0000_0300, wline: lw1,
                    lat: 2, hit: 1'b1, rline: lr0, exp_grant: 2'b10, exp_l2_rd: 1'b0,
                    exp_l2_wr: 1'b1, exp_ready: 2'b10, exp_hit: 2'b10};
        vecs[4] = '{port: 1, rd: 1'b1, wr: 1'b0, redo: 1'b0, addr: 32'hFFFF_FFC0, wline: lw0,
                    lat: 1, hit: 1'b0, rline: lr1, exp_grant: 2'b10, exp_l2_rd: 1'b1,
                    exp_l2_wr: 1'b0, exp_ready: 2'b10, exp_hit: 2'b00};

        rst       = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        req_read  = 2'b00;
        req_write = 2'b00;
        l2_ready  = 1'b0;
        l2_hit    = 1'b0;
        l2_rdata  = '0;
        step();
        step();
        rst = 1'b0;

        chk("rst_grant", 64'(grant), 64'(2'b00));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_strobes", 64'({l2_read, l2_write}), 64'(2'b00));
        chk("rst_l2_addr", 64'(l2_addr), 64'(32'h0));
        chk("rst_req_ready", 64'(req_ready), 64'(2'b00));
        chk("rst_req_hit", 64'(req_hit), 64'(2'b00));
        chk_line("rst_req_rdata", req_rdata, 512'h0);
        chk_line("rst_l2_wdata", l2_wdata, 512'h0);

        // Table-driven single-port transactions.
        for (int i = 0; i < 5; i++) begin
            p   = vecs[i].port;
            tag = $sformatf("v%0d", i);
            req_addr[p*32 +: 32]   = vecs[i].addr;
            req_wdata[p*512 +: 512] = vecs[i].wline;
            req_read[p]  = vecs[i].rd;
            req_write[p] = vecs[i].wr;
            step();
            req_read  = 2'b00;
            req_write = 2'b00;
            chk({tag, "_capture_no_strobe"}, 64'({l2_read, l2_write}), 64'(2'b00));
            req_read[p] = vecs[i].redo;
            step();
            req_read = 2'b00;
            issue_chk(tag, vecs[i].exp_grant, vecs[i].addr, vecs[i].exp_l2_rd, vecs[i].exp_l2_wr);
            chk_line({tag, "_l2_wdata"}, l2_wdata, vecs[i].wline);
            respond(tag, vecs[i].lat, vecs[i].hit, vecs[i].rline,
                    vecs[i].exp_ready, vecs[i].exp_hit, 2'b00);
            idle_tail(tag, 3, vecs[i].rline);
        end

        // Simultaneous requests right after reset: port0 first, then port1.
        reset_dut();
        req_addr = {32'h0000_0200, 32'h0000_0100};
        req_read = 2'b11;
        step();
        req_read = 2'b00;
        step();
        issue_chk("sim0", 2'b01, 32'h0000_0100, 1'b1, 1'b0);
        respond("sim0", 2, 1'b1, lr0, 2'b01, 2'b01, 2'b00);
        step();
        issue_chk("sim1", 2'b10, 32'h0000_0200, 1'b1, 1'b0);
        respond("sim1", 2, 1'b0, lr1, 2'b10, 2'b00, 2'b00);
        idle_tail("sim", 2, lr1);

        // Fairness: each completed port re-requests on its completion edge.
        reset_dut();
        req_read = 2'b11;
        step();
        req_read = 2'b00;
        for (int t = 0; t < 6; t++) begin
            logic [1:0] g;
            logic [1:0] rr;
            g   = (t % 2 == 0) ? 2'b01 : 2'b10;
            rr  = (t < 4) ? g : 2'b00;
            tag = $sformatf("fair%0d", t);
            step();
            issue_chk(tag, g, (t % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200, 1'b1, 1'b0);
            respond(tag, 2, 1'b1, lr2, g, g, rr);
        end
        idle_tail("fair", 2, lr2);
`ifdef L2_ARB_PERF_EN
        chk("perf_grants0", 64'(perf_grants[31:0]), 64'(32'd3));
        chk("perf_grants1", 64'(perf_grants[63:32]), 64'(32'd3));
        chk("perf_stall1_nonzero", 64'(perf_stall[63:32] != 32'd0), 64'(1'b1));
`endif

        // Reset while waiting on L2, then a late l2_ready that must be ignored.
        reset_dut();
        req_addr[31:0] = 32'h0000_0440;
        req_read = 2'b01;
        step();
        req_read = 2'b00;
        step();
        step();
        chk("rstw_busy_before", 64'(busy), 64'(1'b1));
        chk("rstw_grant_before", 64'(grant), 64'(2'b01));
        rst = 1'b1;
        step();
        rst = 1'b0;
        l2_ready = 1'b1;
        l2_hit   = 1'b1;
        l2_rdata = lr0;
        step();
        l2_ready = 1'b0;
        l2_hit   = 1'b0;
        chk("rstw_req_ready", 64'(req_ready), 64'(2'b00));
        chk("rstw_req_hit", 64'(req_hit), 64'(2'b00));
        chk("rstw_grant", 64'(grant), 64'(2'b00));
        chk("rstw_busy", 64'(busy), 64'(1'b0));
        chk("rstw_strobes", 64'({l2_read, l2_write}), 64'(2'b00));
        chk("rstw_l2_addr", 64'(l2_addr), 64'(32'h0));
        chk_line("rstw_req_rdata", req_rdata, 512'h0);
        chk_line("rstw_l2_wdata", l2_wdata, 512'h0);
        idle_tail("rstw", 3, 512'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 cache port between NUM_REQ L1 caches, for example the I-side and D-side L1.
- Each requester side uses the same pulse-style read/write/ready/hit protocol an L1 drives toward L2.
- Requests are captured into per-port pending slots and served one at a time, round-robin.
- Only one transaction is outstanding at L2 at any time.

Parameters:
- NUM_REQ, 2, number of requesting L1 ports (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, word width.
- BLOCK_SIZE, 16, words per line; LINE_W = BLOCK_SIZE*DATA_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-port address; port i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*LINE_W  per-port writeback line.
- req_read  in  NUM_REQ  per-port read request pulse.
- req_write  in  NUM_REQ  per-port write request pulse.
- req_ready  out  NUM_REQ  per-port completion pulse, one cycle.
- req_hit  out  NUM_REQ  per-port L2 hit flag, valid with req_ready.
- req_rdata  out  LINE_W  shared returned line, valid with any req_ready bit.
- grant  out  NUM_REQ  one-hot port currently owning L2; 0 when idle.
- busy  out  1  high in REQ or WAIT.
- l2_addr  out  ADDR_WIDTH  address to L2.
- l2_wdata  out  LINE_W  line to L2.
- l2_read  out  1  read pulse to L2.
- l2_write  out  1  write pulse to L2.
- l2_ready  in  1  L2 completion.
- l2_hit  in  1  L2 hit, sampled with l2_ready.
- l2_rdata  in  LINE_W  line from L2, sampled with l2_ready.

Behaviour:
- Reset: all outputs 0, pending cleared, state IDLE, rr pointer = 0. Reset mid-transaction abandons it; any late l2_ready is ignored while in IDLE.
- Capture, per port, every edge:
  - If req_read[i] or req_write[i] is high and pending[i] is 0: set pending[i] and latch addr, wdata and op.
  - If both are high, write wins.
  - A pulse while pending[i] is already 1 is dropped.
  - Completion of port i clears pending[i]; a same-cycle new pulse on port i re-sets it (set wins).
- Arbitration: the winner is the first pending port searching from rr pointer upward, with wrap-around.
- FSM:
  - IDLE: if any pending, register grant, l2_addr, l2_wdata, and l2_read or l2_write = 1; go to REQ. Otherwise all L2 strobes stay 0.
  - REQ: drop l2_read/l2_write to 0, so each strobe is exactly one cycle high. If l2_ready is already high, complete as in WAIT; otherwise go to WAIT.
  - WAIT: hold l2_addr and grant. On l2_ready:
    - req_rdata <= l2_rdata; req_hit[g] <= l2_hit; req_ready[g] <= 1 for one cycle.
    - Clear pending[g]; rr pointer <= (g+1) mod NUM_REQ; grant <= 0; go to IDLE.
- Latency:
  - Request pulse at edge T; l2 strobe high from edge T+1.
  - L2 ready sampled at edge R gives req_ready high from edge R.
  - Back-to-back: the next grant issues at the edge after completion. There are no idle bubbles beyond IDLE's single cycle.
- req_ready and req_hit of non-granted ports are always 0.
- req_rdata holds its last value between completions.
- A write completion also returns l2_rdata, which requesters ignore.

Optional Feature:
- Macro: L2_ARB_PERF_EN.
- When defined, adds output perf_grants (NUM_REQ*32), one counter per port incremented on each completion.
- Also adds output perf_stall (NUM_REQ*32), per-port cycles with pending[i]=1 and grant[i]=0.
- All counters saturate at 2^32-1 and clear on rst.
- When undefined, these ports and counters are absent, and the rest of the behaviour is identical.

Test Plan:
- Single read: port0 read pulse with addr 0x0000_0040; L2 ready 3 cycles after l2_read with hit=1 and line L → l2_read high exactly 1 cycle with l2_addr 0x40; req_ready=2'b01 for one cycle; req_hit[0]=1; req_rdata=L.
- Simultaneous requests: port0 read 0x100 and port1 read 0x200 in the same cycle after reset → L2 sees 0x100 first, then 0x200; two separate req_ready pulses in order 01, 10.
- Fairness: both ports re-request immediately on each completion for 6 transactions → grants alternate 0,1,0,1,0,1; neither port is served twice in a row.
- Write priority and redundant pulse: port1 asserts read and write together with addr 0x300, then pulses read again while pending → exactly one L2 access, l2_write=1 and l2_read=0, with l2_wdata equal to the port1 line.
- Zero-wait and reset: L2 ready in REQ state → completion on that edge. Separately, assert rst while in WAIT, then raise l2_ready → all outputs 0 and no req_ready pulse.
- Perf (L2_ARB_PERF_EN): the fairness run yields perf_grants = 3 per port and a nonzero perf_stall for the port that waited.
